// File: rtl/riscv_pkg.sv
// Shared constants for the stage sequencer: opcodes, FSM states, opcode classes
// and the data-memory wait limit.
package riscv_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I_OP = 7'b0010011;
    localparam logic [6:0] OP_I_LD = 7'b0000011;
    localparam logic [6:0] OP_U    = 7'b0110111;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_J    = 7'b1101111;
    localparam logic [6:0] OP_S    = 7'b0100011;

    localparam int         MEM_TIMEOUT = 16;
    localparam logic [3:0] WAIT_LAST   = 4'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_JUMP    = 3'd4,
        CLS_ILLEGAL = 3'd5
    } opclass_e;

endpackage

// File: rtl/seq_opclass.sv
// Combinational opcode classifier: maps a 7-bit RISC-V opcode to the class that
// steers the sequencer after DECODE.
module seq_opclass
    import riscv_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic [2:0] class_o
);

    always_comb begin
        class_o = CLS_ILLEGAL;
        case (opcode_i)
            OP_R, OP_I_OP, OP_U: class_o = CLS_ALU;
            OP_I_LD:             class_o = CLS_LOAD;
            OP_S:                class_o = CLS_STORE;
            OP_B:                class_o = CLS_BRANCH;
            OP_J:                class_o = CLS_JUMP;
            default:             class_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with a
// sticky TRAP for illegal opcodes and data-memory timeouts.
module stage_sequencer
    import riscv_pkg::*;
(
    input  logic        req,
    input  logic        reset,
    input  logic [6:0]  opcode_in,
    input  logic        imem_ack_in,
    input  logic        dmem_ack_in,
    input  logic        branch_taken_in,
    output logic        fetch_en_out,
    output logic        rs_read_out,
    output logic        ex_en_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic        rd_write_en_out,
    output logic        pc_write_out,
    output logic        pc_sel_out,
    output logic [2:0]  state_out,
    output logic [31:0] retired_count_out,
    output logic        illegal_out
);

    state_e      state_q, state_d;
    logic [6:0]  opcode_q, opcode_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:0] retired_q;
    logic        illegal_q, illegal_d;

    logic [6:0]  cls_opcode;
    logic [2:0]  cls_raw;
    opclass_e    cls;

    logic fetch_en, rs_read, ex_en, mem_rd, mem_wr, rd_we, pc_we, pc_sel;

    // DECODE classifies the live opcode; later stages use the latched copy.
    assign cls_opcode = (state_q == ST_DECODE) ? opcode_in : opcode_q;

    seq_opclass u_opclass (
        .opcode_i (cls_opcode),
        .class_o  (cls_raw)
    );

    assign cls = opclass_e'(cls_raw);

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        wait_d    = wait_q;
        illegal_d = illegal_q;
        fetch_en  = 1'b0;
        rs_read   = 1'b1;
        ex_en     = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        rd_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                fetch_en = 1'b1;
                if (imem_ack_in) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                rs_read  = 1'b0;
                opcode_d = opcode_in;
                state_d  = (cls == CLS_ILLEGAL) ? ST_TRAP : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                ex_en  = 1'b1;
                wait_d = '0;
                case (cls)
                    CLS_LOAD, CLS_STORE: state_d = ST_MEMORY;
                    CLS_BRANCH: begin
                        pc_we   = 1'b1;
                        pc_sel  = branch_taken_in;
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_WRITEBACK;
                endcase
            end
            ST_MEMORY: begin
                mem_rd = (cls == CLS_LOAD);
                mem_wr = (cls == CLS_STORE);
                if (dmem_ack_in) begin
                    if (cls == CLS_STORE) begin
                        pc_we   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WRITEBACK;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_TRAP;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ST_WRITEBACK: begin
                rd_we   = 1'b1;
                pc_we   = 1'b1;
                pc_sel  = (cls == CLS_JUMP);
                state_d = ST_FETCH;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_TRAP;
        endcase
        if (state_d == ST_TRAP) illegal_d = 1'b1;
        // Reset masks every strobe immediately, including an in-flight memory access.
        if (reset) begin
            fetch_en = 1'b0;
            rs_read  = 1'b1;
            ex_en    = 1'b0;
            mem_rd   = 1'b0;
            mem_wr   = 1'b0;
            rd_we    = 1'b0;
            pc_we    = 1'b0;
            pc_sel   = 1'b0;
        end
    end

    always_ff @(posedge req) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            opcode_q  <= '0;
            wait_q    <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            if (pc_we) retired_q <= retired_q + 32'd1;
        end
    end

    assign fetch_en_out      = fetch_en;
    assign rs_read_out       = rs_read;
    assign ex_en_out         = ex_en;
    assign mem_read_out      = mem_rd;
    assign mem_write_out     = mem_wr;
    assign rd_write_en_out   = rd_we;
    assign pc_write_out      = pc_we;
    assign pc_sel_out        = pc_sel;
    assign state_out         = state_q;
    assign retired_count_out = retired_q;
    assign illegal_out       = illegal_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: table-driven instruction vectors, random
// instruction streams against a per-instruction cycle model, and reset/trap corners.
module tb_stage_sequencer;

    logic        req = 1'b0;
    logic        reset;
    logic [6:0]  opcode_in;
    logic        imem_ack_in, dmem_ack_in, branch_taken_in;
    logic        fetch_en_out, rs_read_out, ex_en_out, mem_read_out, mem_write_out;
    logic        rd_write_en_out, pc_write_out, pc_sel_out, illegal_out;
    logic [2:0]  state_out;
    logic [31:0] retired_count_out;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_ret;

    stage_sequencer dut (
        .req               (req),
        .reset             (reset),
        .opcode_in         (opcode_in),
        .imem_ack_in       (imem_ack_in),
        .dmem_ack_in       (dmem_ack_in),
        .branch_taken_in   (branch_taken_in),
        .fetch_en_out      (fetch_en_out),
        .rs_read_out       (rs_read_out),
        .ex_en_out         (ex_en_out),
        .mem_read_out      (mem_read_out),
        .mem_write_out     (mem_write_out),
        .rd_write_en_out   (rd_write_en_out),
        .pc_write_out      (pc_write_out),
        .pc_sel_out        (pc_sel_out),
        .state_out         (state_out),
        .retired_count_out (retired_count_out),
        .illegal_out       (illegal_out)
    );

    always #5 req = ~req;

    typedef enum {K_ALU, K_LOAD, K_STORE, K_BRANCH, K_JUMP, K_ILL} kind_t;

    // One cycle of stimulus plus the expected {state, fetch, rs, ex, mr, mw, rdw, pcw, pcsel}.
    typedef struct {
        logic        imem;
        logic        dmem;
        logic        tk;
        logic [6:0]  op;
        logic [10:0] exp;
    } cyc_t;

    typedef struct {
        logic [6:0] op;
        int         iw;
        int         dw;
        logic       tk;
        int         lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] outs();
        return {state_out, fetch_en_out, rs_read_out, ex_en_out, mem_read_out,
                mem_write_out, rd_write_en_out, pc_write_out, pc_sel_out};
    endfunction

    function automatic kind_t kind_of(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0110111: return K_ALU;
            7'b0000011: return K_LOAD;
            7'b0100011: return K_STORE;
            7'b1100011: return K_BRANCH;
            7'b1101111: return K_JUMP;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic cyc_t mk(input int st, input bit fe, input bit ex, input bit mr,
                                input bit mw, input bit rdw, input bit pcw, input bit pcs);
        cyc_t c;
        c.imem = 1'($urandom);
        c.dmem = 1'($urandom);
        c.tk   = 1'($urandom);
        c.op   = 7'($urandom);
        c.exp  = {3'(st), fe, (st != 1), ex, mr, mw, rdw, pcw, pcs};
        return c;
    endfunction

    // Builds the expected cycle sequence of one instruction from the stage rules,
    // applies it, then samples one trailing cycle for end state and retire count.
    task automatic run_instr(input string nm, input logic [6:0] op, input int iw,
                             input int dw, input logic tk, output int lat);
        cyc_t       q[$];
        cyc_t       c;
        logic [2:0] obs[$];
        kind_t      k = kind_of(op);
        bit         trap = 0;
        bit         ld = (k == K_LOAD);
        bit         sw = (k == K_STORE);
        bit         br = (k == K_BRANCH);
        for (int i = 0; i <= iw; i++) begin
            c = mk(0, 1, 0, 0, 0, 0, 0, 0);
            c.imem = (i == iw);
            q.push_back(c);
        end
        c = mk(1, 0, 0, 0, 0, 0, 0, 0);
        c.op = op;
        q.push_back(c);
        if (k == K_ILL) begin
            trap = 1;
        end else begin
            c = mk(2, 0, 1, 0, 0, 0, br, br && tk);
            c.tk = tk;
            q.push_back(c);
            if (ld || sw) begin
                for (int i = 0; i < 16 && i <= dw; i++) begin
                    c = mk(3, 0, 0, ld, sw, 0, sw && (i == dw), 0);
                    c.dmem = (i == dw);
                    q.push_back(c);
                end
                if (dw >= 16) trap = 1;
            end
            if (!trap && !br && !sw) q.push_back(mk(4, 0, 0, 0, 0, 1, 1, k == K_JUMP));
        end
        foreach (q[i]) begin
            imem_ack_in     = q[i].imem;
            dmem_ack_in     = q[i].dmem;
            branch_taken_in = q[i].tk;
            opcode_in       = q[i].op;
            @(negedge req);
            obs.push_back(state_out);
            check($sformatf("%s cyc%0d", nm, i), 64'(outs()), 64'(q[i].exp));
            @(posedge req);
            #1;
        end
        if (!trap) exp_ret = exp_ret + 32'd1;
        imem_ack_in     = 1'b0;
        dmem_ack_in     = 1'($urandom);
        branch_taken_in = 1'($urandom);
        opcode_in       = 7'($urandom);
        @(negedge req);
        obs.push_back(state_out);
        check($sformatf("%s end_state", nm), 64'(state_out), trap ? 64'd5 : 64'd0);
        check($sformatf("%s retired", nm), 64'(retired_count_out), 64'(exp_ret));
        check($sformatf("%s illegal", nm), 64'(illegal_out), 64'(trap));
        @(posedge req);
        #1;
        lat = -1;
        for (int p = 1; p < obs.size(); p++)
            if (lat < 0 && obs[p] == 3'd0 && obs[p-1] != 3'd0) lat = p;
    endtask

    // Reset with acks asserted alongside: strobes masked now, clean FETCH afterwards.
    task automatic do_reset(input string nm);
        reset           = 1'b1;
        imem_ack_in     = 1'b1;
        dmem_ack_in     = 1'b1;
        branch_taken_in = 1'b1;
        @(negedge req);
        check($sformatf("%s gated", nm), 64'(outs() & 11'h0FF), 64'b0_1000000);
        @(posedge req);
        #1;
        reset       = 1'b0;
        imem_ack_in = 1'b0;
        dmem_ack_in = 1'b0;
        exp_ret     = '0;
        @(negedge req);
        check($sformatf("%s state", nm), 64'(outs()), 64'b000_1_1_000000);
        check($sformatf("%s illegal", nm), 64'(illegal_out), 64'd0);
        check($sformatf("%s retired", nm), 64'(retired_count_out), 64'd0);
        @(posedge req);
        #1;
    endtask

    initial begin
        vec_t       vt[$];
        logic [6:0] legal[7];
        int         lat;

        reset           = 1'b1;
        imem_ack_in     = 1'b0;
        dmem_ack_in     = 1'b0;
        branch_taken_in = 1'b0;
        opcode_in       = '0;
        exp_ret         = '0;

        @(posedge req);
        #1;
        @(negedge req);
        check("reset gated", 64'(outs()), 64'b000_0_1_000000);
        check("reset retired", 64'(retired_count_out), 64'd0);
        check("reset illegal", 64'(illegal_out), 64'd0);
        @(posedge req);
        #1;
        reset = 1'b0;
        @(negedge req);
        check("post reset fetch", 64'(outs()), 64'b000_1_1_000000);
        @(posedge req);
        #1;

        vt.push_back('{7'b0110011, 0,  0, 1'b0, 4});
        vt.push_back('{7'b0010011, 2,  0, 1'b0, 6});
        vt.push_back('{7'b0110111, 0,  0, 1'b0, 4});
        vt.push_back('{7'b1101111, 0,  0, 1'b1, 4});
        vt.push_back('{7'b0000011, 0,  0, 1'b0, 5});
        vt.push_back('{7'b0000011, 0,  2, 1'b0, 7});
        vt.push_back('{7'b1100011, 0,  0, 1'b1, 3});
        vt.push_back('{7'b1100011, 0,  0, 1'b0, 3});
        vt.push_back('{7'b0100011, 0,  0, 1'b0, 4});
        vt.push_back('{7'b0100011, 0, 15, 1'b0, 19});
        vt.push_back('{7'b0000011, 1, 15, 1'b0, 21});
        foreach (vt[i]) begin
            run_instr($sformatf("vec%0d", i), vt[i].op, vt[i].iw, vt[i].dw, vt[i].tk, lat);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(vt[i].lat));
        end

        legal = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
                  7'b1100011, 7'b1101111, 7'b0100011};
        for (int n = 0; n < 40; n++) begin
            int dw;
            dw = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 4));
            run_instr($sformatf("rnd%0d", n), legal[$urandom_range(0, 6)],
                      int'($urandom_range(0, 3)), dw, 1'($urandom), lat);
        end

        // Store stalled in MEMORY, then reset lands together with the ack.
        imem_ack_in = 1'b1;
        opcode_in   = 7'b0100011;
        dmem_ack_in = 1'b0;
        repeat (5) begin
            @(posedge req);
            #1;
        end
        @(negedge req);
        check("midmem state", 64'(outs()), 64'b011_0_1_0_0_1_0_0_0);
        @(posedge req);
        #1;
        reset       = 1'b1;
        dmem_ack_in = 1'b1;
        @(negedge req);
        check("midmem reset gated", 64'(outs()), 64'b011_0_1_000000);
        @(posedge req);
        #1;
        reset       = 1'b0;
        dmem_ack_in = 1'b0;
        imem_ack_in = 1'b0;
        exp_ret     = '0;
        @(negedge req);
        check("midmem abort state", 64'(state_out), 64'd0);
        check("midmem abort retired", 64'(retired_count_out), 64'd0);
        @(posedge req);
        #1;

        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        exp_ret = 32'hFFFF_FFFF;
        @(negedge req);
        check("preload count", 64'(retired_count_out), 64'hFFFF_FFFF);
        @(posedge req);
        #1;
        run_instr("wrap", 7'b1100011, 0, 0, 1'b1, lat);

        run_instr("illegal", 7'b1111111, 0, 0, 1'b0, lat);
        for (int i = 0; i < 49; i++) begin
            imem_ack_in     = 1'($urandom);
            dmem_ack_in     = 1'($urandom);
            branch_taken_in = 1'($urandom);
            opcode_in       = 7'($urandom);
            @(negedge req);
            check($sformatf("trap hold %0d", i), 64'({illegal_out, outs()}),
                  64'b1_101_0_1_000000);
            @(posedge req);
            #1;
        end
        do_reset("trap reset");

        run_instr("store timeout", 7'b0100011, 0, 99, 1'b0, lat);
        do_reset("timeout reset");
        run_instr("load after reset", 7'b0000011, 0, 1, 1'b0, lat);
        check("load after reset latency", 64'(lat), 64'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 SHALL have a single clock: req, input, 1, all state updates on posedge req.
REQ-002 SHALL have reset: input, 1; reset is synchronous and active-high.
REQ-003 SHALL have opcode_in, input, 7: opcode field instr[6:0] of the fetched instruction.
REQ-004 SHALL have imem_ack_in, input, 1: instruction word valid this cycle.
REQ-005 SHALL have dmem_ack_in, input, 1: data access complete this cycle.
REQ-006 SHALL have branch_taken_in, input, 1: ALU branch compare result.
REQ-007 SHALL have fetch_en_out, output, 1: request instruction fetch.
REQ-008 SHALL have rs_read_out, output, 1: 0 = decode stage latches this edge; 1 = decode holds.
REQ-009 SHALL have ex_en_out, output, 1: ALU stage enable.
REQ-010 SHALL have mem_read_out and mem_write_out, outputs, 1 each: data memory request.
REQ-011 SHALL have rd_write_en_out, output, 1: register file write strobe.
REQ-012 SHALL have pc_write_out, output, 1: PC update strobe.
REQ-013 SHALL have pc_sel_out, output, 1: 0 = PC+4, 1 = branch/jump target.
REQ-014 SHALL have state_out, output, 3: current state encoding.
REQ-015 SHALL have retired_count_out, output, 32: retired instruction count.
REQ-016 SHALL have illegal_out, output, 1: sticky trap flag.

Function
REQ-017 SHALL implement a Moore FSM: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=5. Outputs decode from the registered state, except pc_sel_out in EXECUTE.
REQ-018 FETCH: fetch_en_out=1; stay until imem_ack_in=1, then DECODE.
REQ-019 DECODE: rs_read_out=0 for exactly this cycle, rs_read_out=1 in every other state. Latch opcode_in into an internal register. Opcode not in {R, I_op, I_ld, U, B, J, S} -> TRAP, otherwise EXECUTE.
REQ-020 EXECUTE: ex_en_out=1. Next state by latched opcode:
- I_ld or S -> MEMORY.
- B -> FETCH, with pc_write_out=1 and pc_sel_out=branch_taken_in.
- J, R, I_op, U -> WRITEBACK.
REQ-021 MEMORY: hold mem_read_out=1 (I_ld) or mem_write_out=1 (S) until dmem_ack_in=1.
- I_ld with ack -> WRITEBACK.
- S with ack -> FETCH, pc_write_out=1 and pc_sel_out=0 on the ack cycle.
REQ-022 MEMORY timeout: 4-bit wait counter clears on entry and increments each cycle without ack. If the 16th consecutive cycle passes without ack -> TRAP. An ack on the 16th cycle is accepted.
REQ-023 WRITEBACK: rd_write_en_out=1 and pc_write_out=1 for one cycle; pc_sel_out=1 only for J; -> FETCH.
REQ-024 TRAP: all enables 0, illegal_out=1; stay until reset.
REQ-025 retired_count_out SHALL increment by 1 on every edge where pc_write_out=1, and wrap from 0xFFFFFFFF to 0.
REQ-026 Latency with 1-cycle acks: ALU/U/J = 4 cycles, branch = 3, store = 4, load = 5, measured FETCH entry to next FETCH entry.
REQ-027 mem_read_out and mem_write_out SHALL never both be 1; no two of {fetch_en_out, ex_en_out, mem_*, rd_write_en_out} SHALL be 1 in the same cycle.

Reset
REQ-028 On a reset edge: state=FETCH, latched opcode=0, wait counter=0, retired_count_out=0, illegal_out=0.
REQ-029 While reset=1, outputs SHALL be gated inactive: enables 0, rs_read_out=1, pc_write_out=0. This includes reset asserted mid-MEMORY, which aborts the access without a count increment.
REQ-030 Reset SHALL take priority over TRAP and over every simultaneous ack.

Structure
REQ-031 Opcode constants (R, I_op, I_ld, U, B, J, S), the state enum and the timeout constant (16) SHALL live in shared package riscv_pkg.
REQ-032 One combinational sub-module, seq_opclass, SHALL map opcode to class {ALU, LOAD, STORE, BRANCH, JUMP, ILLEGAL}.
REQ-033 Target size is 120-400 lines of RTL.

Verification
REQ-034 ADD, opcode 0110011, with imem_ack one cycle after fetch: states 0,1,2,4,0; rd_write_en_out pulses once; retired_count_out=1.
REQ-035 Load, opcode 0000011, dmem_ack after 3 cycles: mem_read_out high for 3 cycles, then WRITEBACK; total 7 cycles.
REQ-036 Branch, opcode 1100011, branch_taken_in=1: pc_write_out=1 and pc_sel_out=1 in EXECUTE, return to FETCH, no rd_write_en_out pulse. Repeat with branch_taken_in=0: pc_sel_out=0.
REQ-037 Opcode 1111111: DECODE -> TRAP, illegal_out=1 held for 50 cycles; reset returns state_out=0 and illegal_out=0.
REQ-038 Store with dmem_ack never asserted: TRAP exactly 16 cycles after MEMORY entry. A second run with ack on cycle 16 retires normally.
REQ-039 Preload retired_count_out to 0xFFFFFFFF via force, retire one instruction: count reads 0. Reset asserted mid-MEMORY: mem_write_out=0 in the same cycle, state_out=0 next cycle.
